// File: rtl/font_pkg.sv
// Shared font definitions: glyph geometry, character codes, banner FSM states.
package font_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    localparam logic [9:0] CH_A     = 10'h0a;
    localparam logic [9:0] CH_T     = 10'h1d;
    localparam logic [9:0] CH_EXCL  = 10'h3f;
    localparam logic [9:0] CH_BLANK = 10'h3e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW,
        ST_HOLD
    } banner_state_t;

endpackage

// File: rtl/text_banner_if.sv
// Character write port: valid/ready beats carrying a font code and a last flag.
interface text_banner_if;
    logic       wr_valid;
    logic [9:0] wr_char;
    logic       wr_last;
    logic       wr_ready;

    modport master (output wr_valid, wr_char, wr_last, input wr_ready);
    modport slave  (input wr_valid, wr_char, wr_last, output wr_ready);
endinterface

// File: rtl/text_banner_store.sv
// Character buffer: one synchronous write port, one combinational read port.
module text_banner_store #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 10
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    // Write the accepted character; contents need no reset.
    always_ff @(posedge Clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/text_banner.sv
// Typewriter HUD text line: loads a string over the write port, reveals it
// one character per tick, and decodes the current pixel into font code/flag.
module text_banner #(
    parameter int         MAX_CHARS  = 16,
    parameter int         X_START    = 200,
    parameter int         Y_START    = 400,
    parameter int         CHAR_W     = font_pkg::CHAR_W,
    parameter int         CHAR_H     = font_pkg::CHAR_H,
    parameter logic [9:0] BLANK_CODE = 10'h3e
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    text_banner_if.slave     wr,
    input  logic             reveal_tick,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic [9:0]       start_x,
    output logic [9:0]       start_y,
    output logic [9:0]       n,
    output logic             is_word,
    output logic             shown
);
    import font_pkg::*;

    localparam int LW = $clog2(MAX_CHARS + 1);
    localparam int AW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int SH = $clog2(CHAR_W);
    localparam logic [9:0] XS = 10'(X_START);
    localparam logic [9:0] YS = 10'(Y_START);
    localparam logic [9:0] YE = 10'(Y_START + CHAR_H);

    banner_state_t state, state_nx;
    logic [LW-1:0] len, rev;
    logic          accept, commit, last_rev;
    logic [9:0]    off, idx, rd_data;
    logic          in_x, in_y;

    assign wr.wr_ready = (state == ST_IDLE || state == ST_LOAD) &&
                         (len < LW'(MAX_CHARS)) && !clear;
    assign accept   = wr.wr_valid && wr.wr_ready;
    // Final beat either flagged explicitly or filling the buffer.
    assign commit   = wr.wr_last || (len == LW'(MAX_CHARS - 1));
    assign last_rev = (rev + LW'(1)) == len;

    // State and counter registers; clear wipes the string from any state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            len   <= '0;
            rev   <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                len <= '0;
                rev <= '0;
            end else if (accept) begin
                len <= len + LW'(1);
                rev <= '0;
            end else if (state == ST_SHOW && reveal_tick) begin
                rev <= rev + LW'(1);
            end
        end
    end

    // Next-state logic: load until commit, reveal until full, then hold.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: if (accept) state_nx = commit ? ST_SHOW : ST_LOAD;
                ST_SHOW:          if (reveal_tick && last_rev) state_nx = ST_HOLD;
                default:          state_nx = state;
            endcase
        end
    end

    text_banner_store #(.DEPTH(MAX_CHARS), .AW(AW), .DW(10)) u_store (
        .Clk (Clk),
        .we  (accept),
        .wa  (AW'(len)),
        .wd  (wr.wr_char),
        .ra  (AW'(idx)),
        .rd  (rd_data)
    );

    // Pixel decode; off wraps for DrawX < X_START, so in_x gates both outputs.
    always_comb begin
        off     = DrawX - XS;
        idx     = off >> SH;
        in_x    = DrawX >= XS;
        in_y    = (DrawY >= YS) && (DrawY < YE);
        is_word = in_x && in_y && (idx < 10'(rev));
        n       = (in_x && idx < 10'(len)) ? rd_data : BLANK_CODE;
    end

    assign start_x = XS;
    assign start_y = YS;
    assign shown   = state == ST_HOLD;

endmodule

// File: tb/tb_text_banner.sv
// Self-checking bench for text_banner against a string/counter reference model.
module tb_text_banner;

    localparam int MAXC = 16;

    logic       Clk = 0, Reset = 0, clear = 0, reveal_tick = 0;
    logic [9:0] DrawX = 0, DrawY = 0;
    logic [9:0] start_x, start_y, n;
    logic       is_word, shown;

    text_banner_if wr ();

    text_banner #(.MAX_CHARS(MAXC)) dut (
        .Clk(Clk), .Reset(Reset), .clear(clear), .wr(wr),
        .reveal_tick(reveal_tick), .DrawX(DrawX), .DrawY(DrawY),
        .start_x(start_x), .start_y(start_y), .n(n),
        .is_word(is_word), .shown(shown)
    );

    always #5 Clk = ~Clk;

    // Reference model: the string as an array plus revealed count.
    int         m_len, m_rev;
    bit         m_committed;
    logic [9:0] m_buf [MAXC];

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return !m_committed && m_len < MAXC && !clear;
    endfunction

    task automatic model_reset();
        m_len = 0; m_rev = 0; m_committed = 0;
    endtask

    // One clock with the given inputs; model advances on the same edge.
    task automatic cycle(input bit v, input logic [9:0] ch, input bit last,
                         input bit tk, input bit clr);
        bit rdy;
        wr.wr_valid = v; wr.wr_char = ch; wr.wr_last = last;
        reveal_tick = tk; clear = clr;
        #1;
        rdy = exp_ready();
        chk("wr_ready", wr.wr_ready, rdy);
        @(posedge Clk);
        if (clr) model_reset();
        else if (v && rdy) begin
            m_buf[m_len] = ch;
            m_len++;
            if (last || m_len == MAXC) begin m_committed = 1; m_rev = 0; end
        end else if (tk && m_committed && m_rev < m_len) m_rev++;
        #1;
        wr.wr_valid = 0; wr.wr_last = 0; reveal_tick = 0; clear = 0;
        chk("shown", shown, m_committed && m_rev == m_len);
    endtask

    task automatic do_reset();
        Reset = 1; wr.wr_valid = 0; clear = 0; reveal_tick = 0;
        @(posedge Clk); #1;
        Reset = 0;
        model_reset();
    endtask

    task automatic check_pix(input int x, input int y);
        logic [9:0] en;
        bit         ew;
        int         ci;
        DrawX = 10'(x); DrawY = 10'(y);
        @(negedge Clk);
        ci = (x - 200) / 8;
        ew = x >= 200 && ci < m_rev && y >= 400 && y < 416;
        en = (x >= 200 && ci < m_len) ? m_buf[ci] : 10'h3e;
        chk($sformatf("is_word@%0d,%0d", x, y), is_word, ew);
        chk($sformatf("n@%0d", x), n, en);
    endtask

    task automatic sweep();
        for (int x = 190; x < 340; x += 1 + $urandom_range(0, 6))
            check_pix(x, 398 + $urandom_range(0, 20));
    endtask

    task automatic write_str(input logic [9:0] s[$], input bit with_last);
        foreach (s[i]) cycle(1, s[i], with_last && i == s.size() - 1, 0, 0);
    endtask

    logic [9:0] fight[$] = '{10'h0f, 10'h12, 10'h10, 10'h11, 10'h1d, 10'h3f};
    logic [9:0] vstr[$]  = '{10'h1f};
    logic [9:0] rs[$];

    initial begin
        wr.wr_valid = 0; wr.wr_char = 0; wr.wr_last = 0;
        do_reset();

        // Reset state
        chk("start_x", start_x, 200);
        chk("start_y", start_y, 400);
        check_pix(200, 400);
        chk("rst_shown", shown, 0);
        cycle(0, 0, 0, 1, 0);

        // FIGHT!: nothing visible until ticks arrive
        write_str(fight, 1);
        chk("fight_shown", shown, 0);
        check_pix(205, 405);
        check_pix(240, 410);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0);
            if ($urandom_range(0, 1)) cycle(0, 0, 0, 0, 0);
        end
        check_pix(223, 405);
        check_pix(224, 405);
        chk("n224", n, 10'h11);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        chk("fight_hold", shown, 1);
        check_pix(200, 400);
        check_pix(247, 415);
        check_pix(217, 408);
        chk("n217", n, 10'h10);
        cycle(1, 10'h0a, 1, 1, 0);   // refused in HOLD, tick ignored
        sweep();
        // Underflow of off and row boundary
        check_pix(199, 405);
        chk("n199", n, 10'h3e);
        check_pix(210, 416);
        check_pix(210, 399);

        // 17 beats with no last: auto-commit at 16
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) cycle(1, 10'($urandom_range(10, 63)), 0, 0, 0);
        chk("full_len", m_len, 16);
        check_pix(328, 405);
        chk("n328", n, 10'h3e);
        check_pix(327, 405);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0);
        sweep();

        // clear with a beat mid-LOAD
        cycle(0, 0, 0, 0, 1);
        write_str(fight[0:2], 0);
        cycle(1, 10'h20, 0, 0, 1);
        check_pix(200, 405);
        cycle(0, 0, 0, 1, 0);
        check_pix(200, 405);

        // Reset during SHOW with rev=2, then single char V
        write_str(fight, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check_pix(210, 405);
        do_reset();
        chk("rst_shown2", shown, 0);
        check_pix(210, 405);
        write_str(vstr, 1);
        cycle(0, 0, 0, 1, 0);
        check_pix(200, 405);
        check_pix(207, 405);
        check_pix(208, 405);
        check_pix(199, 405);

        // Random rounds
        for (int r = 0; r < 25; r++) begin
            cycle(0, 0, 0, 0, 1);
            rs.delete();
            for (int i = 0; i < $urandom_range(1, 18); i++) rs.push_back(10'($urandom_range(10, 63)));
            foreach (rs[i]) begin
                cycle(1, rs[i], ($urandom_range(0, 9) == 0) || i == rs.size() - 1,
                      $urandom_range(0, 1), $urandom_range(0, 40) == 0);
                if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, $urandom_range(0, 1), 0);
            end
            for (int i = 0; i < $urandom_range(0, 20); i++)
                cycle($urandom_range(0, 1), 10'($urandom_range(10, 63)), 0, $urandom_range(0, 1), 0);
            sweep();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
